arp_note_decoder: RTL and testbench
===================================

ARP_NOTE_DECODER -- requirements
Module: arp_note_decoder

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-002 Parameter DUR_W, default 16, width of note-duration field.
REQ-003 CLK  input  1  system clock, all state on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Enable  input  1  decode enable; 0 freezes sampling, duration and event generation.
REQ-006 notes  input  8  one-hot note lines from the arpeggiator outputs out0..out7 (bit k = out k).
REQ-007 ev_valid  output  1  FIFO head holds an event.
REQ-008 ev_ready  input  1  consumer accepts head event when ev_valid=1.
REQ-009 ev_note  output  3  note index of head event.
REQ-010 ev_on  output  1  1 = note-on, 0 = note-off.
REQ-011 ev_dur  output  DUR_W  cycles the note was held (note-off only; 0 for note-on).
REQ-012 multi_err  output  1  sticky: multi-hot input seen.
REQ-013 overflow  output  1  sticky: events dropped for lack of FIFO space.
REQ-014 clr_err  input  1  synchronous clear of multi_err and overflow.

Function
REQ-015 When Enable=1, notes SHALL be registered every cycle into a sample stage; decode operates on the sample stage against the stored current-note state (cur_valid, cur_idx).
REQ-016 Decode: all-zero = silence; one-hot = index of set bit; multi-hot = lowest set bit index, and multi_err SHALL set.
REQ-017 Silence -> note k: push ON(k, dur=0); cur := k, duration counter := 1.
REQ-018 Note j -> note k, k!=j: push OFF(j, dur) then ON(k) in the same cycle, OFF ahead of ON; counter := 1.
REQ-019 Note j -> silence: push OFF(j, dur); cur_valid := 0; counter := 0.
REQ-020 Unchanged note: counter increments, saturating at 2^DUR_W-1; no event.
REQ-021 Latency: a notes change stable before rising edge n SHALL produce ev_valid=1 after edge n+1 (FIFO empty case).
REQ-022 FIFO: DEPTH entries {note,on,dur}, first-word-fall-through; pop on ev_valid&ev_ready.
REQ-023 Free space for a push SHALL include a same-cycle pop (free = DEPTH - count + pop).
REQ-024 Pushes are atomic per cycle: if free < events required, ALL events of that cycle SHALL be dropped, overflow SHALL set, and cur/counter SHALL still update as if pushed.
REQ-025 Enable=0: sample stage, cur state and counter hold; FIFO pops continue; no pushes.
REQ-026 ev_valid SHALL be 0 and ev_note/ev_on/ev_dur SHALL be 0 when FIFO empty.
REQ-027 clr_err=1 clears sticky flags next edge; a new error in the same cycle SHALL win (flag stays 1).

Reset
REQ-028 RESET=0 SHALL immediately clear sample stage, cur_valid, counter, FIFO pointers/count, multi_err, overflow; ev_valid=0, ev_note=0, ev_on=0, ev_dur=0.
REQ-029 Reset mid-operation SHALL discard all queued events; after release the first decoded non-silence produces ON only (no OFF for the pre-reset note).

Verification
REQ-030 notes=0x00 -> 0x04 held 3 cycles -> 0x00, ev_ready=1: events ON(2,0) then OFF(2,3).
REQ-031 notes 0x01 (2 cycles) -> 0x80, ev_ready=1: OFF(0,2) before ON(7,0) in FIFO order; ON(0) first.
REQ-032 ev_ready=0, DEPTH=4, produce 3 events then a j->k change: both dropped, overflow=1, count stays 3; clr_err -> overflow=0.
REQ-033 notes=0x0A: ON(1), multi_err=1; clr_err with another 0x0C same cycle -> multi_err stays 1.
REQ-034 DUR_W=4, note held 20 cycles then silence: OFF dur=15 (saturated).
REQ-035 RESET=0 with 3 queued events and note held -> ev_valid=0 immediately; after release and notes unchanged, one ON event only.

Source files
------------

// File: rtl/arp_note_decoder.sv
// -----------------------------------------------------------------------------
// arp_note_decoder
//
// Turns the one-hot note lines of an arpeggiator into a stream of note-on /
// note-off events. Each note-off carries the number of decode cycles the note
// was held. Events queue in a small first-word-fall-through FIFO.
//
// Ports
//   CLK        system clock, all state on rising edge
//   RESET      asynchronous active-low reset
//   Enable     1 = sample/decode/generate events, 0 = freeze (pops continue)
//   notes      one-hot note lines, bit k = arpeggiator output k
//   ev_valid   FIFO head holds an event
//   ev_ready   consumer accepts the head event when ev_valid=1
//   ev_note    note index of head event
//   ev_on      1 = note-on, 0 = note-off
//   ev_dur     held duration in cycles (note-off only, 0 for note-on)
//   multi_err  sticky: a multi-hot sample was decoded
//   overflow   sticky: a cycle's events were dropped for lack of FIFO space
//   clr_err    synchronous clear of both sticky flags
// -----------------------------------------------------------------------------
module arp_note_decoder #(
  parameter int DEPTH = 4,
  parameter int DUR_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Enable,
  input  logic [7:0]       notes,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [2:0]       ev_note,
  output logic             ev_on,
  output logic [DUR_W-1:0] ev_dur,
  output logic             multi_err,
  output logic             overflow,
  input  logic             clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 3 + 1 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  // Duration counter increment that sticks at the top of its range.
  function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
    sat_inc = (v == DUR_MAX) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: registered note sample
  // ---------------------------------------------------------------------------
  logic [7:0] samp_p0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      samp_p0 <= '0;
    end else if (Enable) begin
      samp_p0 <= notes;
    end
  end

  // Decode: lowest set bit wins, so a multi-hot sample still yields a note.
  logic       dec_vld;
  logic [2:0] dec_idx;
  logic       dec_multi;

  always_comb begin
    dec_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (samp_p0[i]) dec_idx = 3'(i);
    end
    dec_vld   = |samp_p0;
    dec_multi = |(samp_p0 & (samp_p0 - 8'd1));
  end

  // ---------------------------------------------------------------------------
  // Stage p1: current-note state, duration counter and event FIFO
  // ---------------------------------------------------------------------------
  logic             cur_vld_p1;
  logic [2:0]       cur_idx_p1;
  logic [DUR_W-1:0] dur_cnt_p1;

  logic             cur_vld_nxt;
  logic [2:0]       cur_idx_nxt;
  logic [DUR_W-1:0] dur_cnt_nxt;
  logic [1:0]       need;
  logic [EW-1:0]    ev0;
  logic [EW-1:0]    ev1;

  // Event generation. On a note change the OFF goes in slot 0 so it lands
  // ahead of the following ON in FIFO order.
  always_comb begin
    need        = 2'd0;
    ev0         = '0;
    ev1         = '0;
    cur_vld_nxt = cur_vld_p1;
    cur_idx_nxt = cur_idx_p1;
    dur_cnt_nxt = dur_cnt_p1;
    if (dec_vld) begin
      if (!cur_vld_p1) begin
        need        = 2'd1;
        ev0         = {dec_idx, 1'b1, {DUR_W{1'b0}}};
        dur_cnt_nxt = DUR_W'(1);
      end else if (dec_idx != cur_idx_p1) begin
        need        = 2'd2;
        ev0         = {cur_idx_p1, 1'b0, dur_cnt_p1};
        ev1         = {dec_idx, 1'b1, {DUR_W{1'b0}}};
        dur_cnt_nxt = DUR_W'(1);
      end else begin
        dur_cnt_nxt = sat_inc(dur_cnt_p1);
      end
      cur_vld_nxt = 1'b1;
      cur_idx_nxt = dec_idx;
    end else if (cur_vld_p1) begin
      need        = 2'd1;
      ev0         = {cur_idx_p1, 1'b0, dur_cnt_p1};
      cur_vld_nxt = 1'b0;
      dur_cnt_nxt = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cur_vld_p1 <= 1'b0;
      cur_idx_p1 <= '0;
      dur_cnt_p1 <= '0;
    end else if (Enable) begin
      // Updates even when the cycle's events are dropped by overflow.
      cur_vld_p1 <= cur_vld_nxt;
      cur_idx_p1 <= cur_idx_nxt;
      dur_cnt_p1 <= dur_cnt_nxt;
    end
  end

  // FIFO bookkeeping. A pop in the same cycle frees a slot for the push, and
  // a two-event cycle is all-or-nothing.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [CW-1:0] push_n;

  always_comb begin
    pop     = ev_valid & ev_ready;
    free    = CW'(DEPTH) - count + CW'(pop);
    push_ok = Enable && (need != 2'd0) && (free >= CW'(need));
    drop    = Enable && (need != 2'd0) && !push_ok;
    push_n  = push_ok ? CW'(need) : '0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + push_n - CW'(pop);
    end
  end

  // Storage carries data only; validity comes from count.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= ev0;
      if (need == 2'd2) mem[wr_ptr + AW'(1)] <= ev1;
    end
  end

  // Sticky flags: a fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      multi_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      multi_err <= (multi_err & ~clr_err) | (Enable & dec_multi);
      overflow  <= (overflow & ~clr_err) | drop;
    end
  end

  // Head outputs are forced to zero while the FIFO is empty.
  logic [EW-1:0] head;

  always_comb begin
    head     = mem[rd_ptr];
    ev_valid = (count != '0);
    ev_note  = ev_valid ? head[EW-1 -: 3] : 3'd0;
    ev_on    = ev_valid ? head[DUR_W] : 1'b0;
    ev_dur   = ev_valid ? head[DUR_W-1:0] : '0;
  end

endmodule

// File: tb/tb_arp_note_decoder.sv
module tb_arp_note_decoder;

  localparam int DEPTH = 4;
  localparam int DUR_W = 4;
  localparam int DMAX  = 15;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             Enable = 1'b0;
  logic [7:0]       notes = 8'h00;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [2:0]       ev_note;
  logic             ev_on;
  logic [DUR_W-1:0] ev_dur;
  logic             multi_err;
  logic             overflow;
  logic             clr_err = 1'b0;

  arp_note_decoder #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .CLK(CLK), .RESET(RESET), .Enable(Enable), .notes(notes),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_note(ev_note),
    .ev_on(ev_on), .ev_dur(ev_dur), .multi_err(multi_err),
    .overflow(overflow), .clr_err(clr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] note;
    logic       on;
    logic [3:0] dur;
  } ev_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: event list semantics with plain integers and a queue.
  ev_t  mq[$];
  ev_t  dut_log[$];
  logic [7:0] m_samp;
  int   m_cur;
  int   m_cnt;
  bit   m_multi;
  bit   m_ovf;

  function automatic ev_t mk(int n, int o, int d);
    ev_t e;
    e.note = 3'(n);
    e.on   = 1'(o);
    e.dur  = 4'(d);
    return e;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_samp  = 8'h00;
    m_cur   = -1;
    m_cnt   = 0;
    m_multi = 0;
    m_ovf   = 0;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  function automatic void model_step();
    bit  pop;
    bit  mset;
    bit  oset;
    int  idx;
    int  free;
    ev_t evs[$];
    pop  = (mq.size() != 0) && ev_ready;
    mset = 0;
    oset = 0;
    if (Enable) begin
      idx = -1;
      for (int i = 0; i < 8; i++) if (m_samp[i] && idx < 0) idx = i;
      mset = ($countones(m_samp) > 1);
      if (idx >= 0 && m_cur < 0) begin
        evs.push_back(mk(idx, 1, 0));
        m_cnt = 1;
      end else if (idx >= 0 && idx != m_cur) begin
        evs.push_back(mk(m_cur, 0, m_cnt));
        evs.push_back(mk(idx, 1, 0));
        m_cnt = 1;
      end else if (idx < 0 && m_cur >= 0) begin
        evs.push_back(mk(m_cur, 0, m_cnt));
        m_cnt = 0;
      end else if (idx >= 0) begin
        m_cnt = (m_cnt < DMAX) ? m_cnt + 1 : DMAX;
      end
      m_cur = idx;
      free = DEPTH - mq.size() + (pop ? 1 : 0);
      if (pop) void'(mq.pop_front());
      if (evs.size() > free) oset = 1;
      else foreach (evs[i]) mq.push_back(evs[i]);
      m_samp = notes;
    end else if (pop) begin
      void'(mq.pop_front());
    end
    m_multi = (m_multi && !clr_err) || mset;
    m_ovf   = (m_ovf && !clr_err) || oset;
  endfunction

  // One clock: log any accepted event, step the model, sample #1 after edge.
  task automatic tick();
    if (RESET) begin
      if (ev_valid && ev_ready) dut_log.push_back({ev_note, ev_on, ev_dur});
      model_step();
    end else begin
      model_reset();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [7:0] n, input int cycles);
    notes = n;
    repeat (cycles) tick();
  endtask

  task automatic do_reset();
    Enable = 1'b1; ev_ready = 1'b0; clr_err = 1'b0; notes = 8'h00;
    #2 RESET = 1'b0;
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    dut_log.delete();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    n_cmp++; if ({ev_note, ev_on, ev_dur} !== 8'h00) begin n_fail++; $display("FAIL reset_head: got %h want 00", {ev_note, ev_on, ev_dur}); end
    n_cmp++; if ({multi_err, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {multi_err, overflow}); end
    do_reset();
  endtask

  task automatic test_on_off();
    do_reset();
    ev_ready = 1'b1;
    notes = 8'h04;
    tick();
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b want 0", ev_valid); end
    tick();
    n_cmp++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", ev_valid); end
    n_cmp++; if ({ev_note, ev_on, ev_dur} !== mk(2, 1, 0)) begin n_fail++; $display("FAIL latency_head: got %h want %h", {ev_note, ev_on, ev_dur}, mk(2, 1, 0)); end
    tick();
    hold(8'h00, 4);
    n_cmp++; if (dut_log.size() !== 2) begin n_fail++; $display("FAIL on_off_count: got %0d want 2", dut_log.size()); end
    if (dut_log.size() == 2) begin
      n_cmp++; if (dut_log[0] !== mk(2, 1, 0)) begin n_fail++; $display("FAIL on_off_ev0: got %h want %h", dut_log[0], mk(2, 1, 0)); end
      n_cmp++; if (dut_log[1] !== mk(2, 0, 3)) begin n_fail++; $display("FAIL on_off_ev1: got %h want %h", dut_log[1], mk(2, 0, 3)); end
    end
  endtask

  task automatic test_change();
    do_reset();
    ev_ready = 1'b1;
    hold(8'h01, 2);
    hold(8'h80, 3);
    hold(8'h00, 4);
    n_cmp++; if (dut_log.size() !== 4) begin n_fail++; $display("FAIL change_count: got %0d want 4", dut_log.size()); end
    if (dut_log.size() == 4) begin
      n_cmp++; if (dut_log[0] !== mk(0, 1, 0)) begin n_fail++; $display("FAIL change_ev0: got %h want %h", dut_log[0], mk(0, 1, 0)); end
      n_cmp++; if (dut_log[1] !== mk(0, 0, 2)) begin n_fail++; $display("FAIL change_ev1: got %h want %h", dut_log[1], mk(0, 0, 2)); end
      n_cmp++; if (dut_log[2] !== mk(7, 1, 0)) begin n_fail++; $display("FAIL change_ev2: got %h want %h", dut_log[2], mk(7, 1, 0)); end
      n_cmp++; if (dut_log[3] !== mk(7, 0, 3)) begin n_fail++; $display("FAIL change_ev3: got %h want %h", dut_log[3], mk(7, 0, 3)); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    hold(8'h01, 2);
    hold(8'h00, 2);
    hold(8'h02, 2);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b want 0", overflow); end
    hold(8'h04, 2);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if ({ev_note, ev_on, ev_dur} !== mk(0, 1, 0)) begin n_fail++; $display("FAIL ovf_head: got %h want %h", {ev_note, ev_on, ev_dur}, mk(0, 1, 0)); end
    ev_ready = 1'b1;
    repeat (5) tick();
    n_cmp++; if (dut_log.size() !== 3) begin n_fail++; $display("FAIL ovf_count: got %0d want 3", dut_log.size()); end
    if (dut_log.size() == 3) begin
      n_cmp++; if (dut_log[1] !== mk(0, 0, 2)) begin n_fail++; $display("FAIL ovf_ev1: got %h want %h", dut_log[1], mk(0, 0, 2)); end
      n_cmp++; if (dut_log[2] !== mk(1, 1, 0)) begin n_fail++; $display("FAIL ovf_ev2: got %h want %h", dut_log[2], mk(1, 1, 0)); end
    end
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", ev_valid); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_multi();
    do_reset();
    ev_ready = 1'b1;
    hold(8'h0A, 2);
    n_cmp++; if (multi_err !== 1'b1) begin n_fail++; $display("FAIL multi_set: got %b want 1", multi_err); end
    n_cmp++; if ({ev_valid, ev_note, ev_on} !== 5'b1_001_1) begin n_fail++; $display("FAIL multi_head: got %b want 10011", {ev_valid, ev_note, ev_on}); end
    hold(8'h0C, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (multi_err !== 1'b1) begin n_fail++; $display("FAIL multi_clr_race: got %b want 1", multi_err); end
    hold(8'h00, 2);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (multi_err !== 1'b0) begin n_fail++; $display("FAIL multi_clear: got %b want 0", multi_err); end
  endtask

  task automatic test_saturate();
    do_reset();
    ev_ready = 1'b1;
    hold(8'h10, 20);
    hold(8'h00, 4);
    n_cmp++; if (dut_log.size() !== 2) begin n_fail++; $display("FAIL sat_count: got %0d want 2", dut_log.size()); end
    if (dut_log.size() == 2) begin
      n_cmp++; if (dut_log[1] !== mk(4, 0, 15)) begin n_fail++; $display("FAIL sat_dur: got %h want %h", dut_log[1], mk(4, 0, 15)); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    ev_ready = 1'b1;
    hold(8'h04, 3);
    Enable = 1'b0;
    hold(8'h00, 5);
    n_cmp++; if (dut_log.size() !== 1) begin n_fail++; $display("FAIL en_frozen: got %0d want 1", dut_log.size()); end
    Enable = 1'b1;
    hold(8'h00, 4);
    n_cmp++; if (dut_log.size() !== 2) begin n_fail++; $display("FAIL en_count: got %0d want 2", dut_log.size()); end
    if (dut_log.size() == 2) begin
      n_cmp++; if (dut_log[1] !== mk(2, 0, 3)) begin n_fail++; $display("FAIL en_dur: got %h want %h", dut_log[1], mk(2, 0, 3)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(8'h01, 2);
    hold(8'h00, 2);
    hold(8'h02, 3);
    n_cmp++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_queued: got %b want 1", ev_valid); end
    #2 RESET = 1'b0;
    model_reset();
    #1;
    n_cmp++; if ({ev_valid, ev_note, ev_on, ev_dur} !== 9'h000) begin n_fail++; $display("FAIL rmid_async: got %h want 000", {ev_valid, ev_note, ev_on, ev_dur}); end
    @(posedge CLK);
    #1 RESET = 1'b1;
    dut_log.delete();
    ev_ready = 1'b1;
    repeat (5) tick();
    n_cmp++; if (dut_log.size() !== 1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", dut_log.size()); end
    if (dut_log.size() == 1) begin
      n_cmp++; if (dut_log[0] !== mk(1, 1, 0)) begin n_fail++; $display("FAIL rmid_ev: got %h want %h", dut_log[0], mk(1, 1, 0)); end
    end
  endtask

  task automatic test_random();
    int r;
    ev_t exp_head;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r < 5) notes = notes;
      else if (r < 7) notes = 8'h00;
      else if (r < 9) notes = 8'h01 << $urandom_range(0, 7);
      else notes = 8'($urandom);
      Enable   = ($urandom_range(0, 9) != 0);
      ev_ready = ($urandom_range(0, 3) != 0);
      clr_err  = ($urandom_range(0, 19) == 0);
      tick();
      exp_head = (mq.size() != 0) ? mq[0] : ev_t'(8'h00);
      n_cmp++; if (ev_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, ev_valid, mq.size() != 0); end
      n_cmp++; if ({ev_note, ev_on, ev_dur} !== exp_head) begin n_fail++; $display("FAIL rnd_head c=%0d: got %h want %h", c, {ev_note, ev_on, ev_dur}, exp_head); end
      n_cmp++; if (multi_err !== m_multi) begin n_fail++; $display("FAIL rnd_multi c=%0d: got %b want %b", c, multi_err, m_multi); end
      n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, overflow, m_ovf); end
    end
    clr_err = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_on_off();
    test_change();
    test_overflow();
    test_multi();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
